uart_tx_stream: RTL
===================

# uart_tx_stream

Parametrised, synthesizable UART transmitter with an input byte FIFO. It serialises queued words onto a single line in 8N1-style framing, with configurable data width, baud divisor, oversample factor, stop-bit count and FIFO depth. It drives `serial_in` of `mcu_top` in system benches and FPGA bring-up, replacing timed behavioural stimulus with a cycle-exact, reusable source.

## Interface
Parameters:
- `DATA_BITS`, 8: payload bits per frame, 5..9.
- `DVSR`, 26: clock cycles per oversample tick, ≥1.
- `OVERSAMPLE`, 16: ticks per bit period. One bit lasts `DVSR*OVERSAMPLE` clocks (416 at defaults).
- `STOP_BITS`, 1: number of stop bits, 1 or 2.
- `FIFO_DEPTH`, 4: queue entries, power of two, ≥2.

Ports:
- `CLOCK`  in  1: single clock, rising-edge.
- `RESET`  in  1: synchronous, active-high.
- `wr_en`  in  1: push `wr_data` when `full`=0.
- `wr_data`  in  `DATA_BITS`: word to transmit, LSB sent first.
- `full`  out  1: FIFO holds `FIFO_DEPTH` entries.
- `level`  out  `$clog2(FIFO_DEPTH)+1`: entries queued, excluding the frame in flight.
- `busy`  out  1: a frame is being shifted out (state ≠ IDLE).
- `tx_done`  out  1: one-cycle pulse in the last cycle of the final stop bit.
- `serial_out`  out  1: line, idle high.

## Operation
- FIFO: circular buffer with wrapping read/write pointers and a separate count.
  - A push when `full`=1 is dropped, including when a pop happens in the same cycle. Pointers and count are unchanged.
  - A push and a pop in the same cycle with `full`=0 leave `level` unchanged.
- FSM states: IDLE → START → DATA → (PARITY) → STOP → IDLE or START.
  - IDLE: if `level`>0, pop the head into the shift register and go to START.
  - START: drive 0 for one bit period.
  - DATA: drive `shreg[0]` and shift right each bit period. After `DATA_BITS` bits, go to PARITY if enabled, else STOP.
  - STOP: drive 1 for `STOP_BITS` periods. Assert `tx_done` in the final cycle.
    - If the FIFO is non-empty at that final cycle, pop and go directly to START. This gives back-to-back frames with no idle gap.
    - Otherwise go to IDLE.
- Timing counters:
  - The tick counter counts 0..`DVSR-1` and produces a tick.
  - The sample counter counts ticks 0..`OVERSAMPLE-1` and produces the bit-period end.
  - The bit counter counts DATA and STOP bits.
  - All counters clear on state entry.
- `serial_out` is registered and glitch-free.
- Reset values: `serial_out`=1, `busy`=0, `tx_done`=0, `full`=0, `level`=0, state IDLE, all pointers and counters 0.
- `RESET` mid-frame aborts the frame and flushes the FIFO. The line returns high on the next edge.

## Timing
- Write to an empty FIFO in IDLE at edge N:
  - `level`=1 after N.
  - Pop at N+1, so `level`=0 and state is START.
  - `serial_out` falls after edge N+2.
- Each bit lasts exactly `DVSR*OVERSAMPLE` cycles.
- Frame length is `(1+DATA_BITS+P+STOP_BITS)*DVSR*OVERSAMPLE` cycles, where P=1 with parity and P=0 without.
- `full` and `level` update on the edge after a push or pop. `full` is combinational from the count register.
- `busy` rises with START and falls on entry to IDLE.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - The PARITY state is compiled in.
  - It inserts one bit equal to the even parity of the data (XOR of all data bits) between DATA and STOP.
- `UART_TX_PARITY_EN` undefined:
  - No parity state or logic exists.
  - DATA proceeds directly to STOP.

## Test plan
- Reset, no writes → `serial_out`=1, `busy`=0, `level`=0 for 1000 cycles.
- Defaults, write 0x05 → line reads 0,1,0,1,0,0,0,0,0,1, each bit 416 cycles. One `tx_done` pulse after 4160 cycles from the start-bit fall.
- Write 0x05, 0x0A, 0x0C on consecutive cycles → three frames back-to-back with no idle gap. `level` sequence is 1,1,2 then drains.
- FIFO_DEPTH=4, write 6 words in 6 cycles while the first frame runs → 4 queued, 1 in flight, 1 dropped. `full`=1 and only 5 frames appear.
- Assert `RESET` at bit 3 of a frame with 2 words queued → `serial_out`=1 next cycle, `level`=0, `busy`=0, no further frames.
- With `UART_TX_PARITY_EN`, write 0x07 → parity bit 1 after data, frame length 11 bits. With 0x03 → parity bit 0.

Source files
------------

// File: rtl/uart_tx_stream.sv
// uart_tx_stream: UART transmitter fed by a small byte FIFO.
// Queued words are sent LSB first as start, data, optional parity and stop
// bits. Frames that are already queued go out back-to-back with no idle gap.
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// between the data and stop bits.
// Ports:
//   CLOCK, RESET   rising-edge clock, synchronous active-high reset
//   wr_en, wr_data push a word (dropped while full)
//   full           FIFO holds FIFO_DEPTH entries (decoded from the count flop)
//   level          entries queued, not counting the frame in flight
//   busy           a frame is being shifted out
//   tx_done        one-cycle pulse in the last cycle of the final stop bit
//   serial_out     registered line output, idle high
module uart_tx_stream #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned DVSR       = 26,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          CLOCK,
  input  logic                          RESET,
  input  logic                          wr_en,
  input  logic [DATA_BITS-1:0]          wr_data,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          busy,
  output logic                          tx_done,
  output logic                          serial_out
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned TICK_W = (DVSR > 1) ? $clog2(DVSR) : 1;
  localparam int unsigned SAMP_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int unsigned BIT_W  = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_e;

  state_e               state_q, state_d;
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_BITS-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [TICK_W-1:0]    tick_q, tick_d;
  logic [SAMP_W-1:0]    samp_q, samp_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 serial_out_q, serial_out_d;
  logic                 busy_q, busy_d;
  logic                 tx_done_q, tx_done_d;
`ifdef UART_TX_PARITY_EN
  logic                 par_q, par_d;
`endif
  logic                 push, pop, tick, bit_end;
  logic [DATA_BITS-1:0] head;

  assign full       = (count_q == CNT_W'(FIFO_DEPTH));
  assign level      = count_q;
  assign busy       = busy_q;
  assign tx_done    = tx_done_q;
  assign serial_out = serial_out_q;
  assign head       = mem_q[rd_ptr_q];

  // FIFO bookkeeping; a push while full is dropped even if a pop happens too
  always_comb begin
    push     = wr_en && !full;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  // Bit timing: DVSR clocks per tick, OVERSAMPLE ticks per bit
  assign tick    = (tick_q == TICK_W'(DVSR - 1));
  assign bit_end = tick && (samp_q == SAMP_W'(OVERSAMPLE - 1));

  // Next state, counters and line value
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    pop       = 1'b0;
    tx_done_d = 1'b0;
    tick_d    = tick ? '0 : tick_q + TICK_W'(1);
    samp_d    = bit_end ? '0 : (tick ? samp_q + SAMP_W'(1) : samp_q);
    bit_d     = bit_q;
`ifdef UART_TX_PARITY_EN
    par_d     = par_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          shreg_d = head;
`ifdef UART_TX_PARITY_EN
          par_d   = ^head;
`endif
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        if (bit_end) begin
          shreg_d = shreg_q >> 1;
          if (bit_q == BIT_W'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          if (bit_q == BIT_W'(STOP_BITS - 1)) begin
            tx_done_d = 1'b1;
            // Pop straight into the next frame to avoid an idle gap
            if (count_q != '0) begin
              pop     = 1'b1;
              shreg_d = head;
`ifdef UART_TX_PARITY_EN
              par_d   = ^head;
`endif
              state_d = S_START;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Counters restart on every state entry, including STOP -> START
    if (state_d != state_q || state_q == S_IDLE) begin
      tick_d = '0;
      samp_d = '0;
      bit_d  = '0;
    end
    busy_d = (state_d != S_IDLE);
    // Line lags the state by one flop so it is glitch-free
    unique case (state_q)
      S_START:    serial_out_d = 1'b0;
      S_DATA:     serial_out_d = shreg_q[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY:   serial_out_d = par_q;
`endif
      default:    serial_out_d = 1'b1;
    endcase
  end

  // Storage array needs no reset; pointers and count define validity
  always_ff @(posedge CLOCK) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      tick_q       <= '0;
      samp_q       <= '0;
      bit_q        <= '0;
      shreg_q      <= '0;
      serial_out_q <= 1'b1;
      busy_q       <= 1'b0;
      tx_done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      tick_q       <= tick_d;
      samp_q       <= samp_d;
      bit_q        <= bit_d;
      shreg_q      <= shreg_d;
      serial_out_q <= serial_out_d;
      busy_q       <= busy_d;
      tx_done_q    <= tx_done_d;
`ifdef UART_TX_PARITY_EN
      par_q        <= par_d;
`endif
    end
  end

endmodule
